serial_addsub_ctrl: RTL and testbench

Bit-serial signed add/subtract controller. It accepts one N-bit two's-complement operation per request and sequences a 1-bit full adder LSB-first over N cycles. At the end it produces the sum/difference, carry-out and the signed overflow flag. The overflow flag is evaluated from the operation select, the operand sign bits and the result sign bit. The block sits between the front-panel/input logic and the display path of the arithmetic lab datapath.

---
 rtl/serial_addsub_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial signed add/subtract controller: one N-bit operation per start,
// processed LSB-first over N cycles, reporting result, carry-out and signed overflow.
module serial_addsub_ctrl #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [N-1:0]  opa_q,       opa_d;
    logic [N-1:0]  opb_q,       opb_d;
    logic [N-1:0]  res_q,       res_d;
    logic          carry_q,     carry_d;
    logic          s_q,         s_d;
    logic          sa_q,        sa_d;
    logic          sb_q,        sb_d;
    logic          carry_out_q, carry_out_d;
    logic          ovf_q,       ovf_d;

    logic sum_bit;
    logic maj_bit;

    assign sum_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign maj_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    always_comb begin
        // NOTE: every _d starts as its _q so each path holds state and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        carry_d     = carry_q;
        s_d         = s_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                    state_d = S_RUN;
                    opa_d   = a;
                    opb_d   = b ^ {N{sub}};
                    carry_d = sub;
                    s_d     = sub;
                    sa_d    = a[N-1];
                    sb_d    = b[N-1];
                    cnt_d   = '0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = maj_bit;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = {sum_bit, res_q[N-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // sum_bit is the result MSB on this final edge.
                    state_d     = S_DONE;
                    carry_out_d = maj_bit;
                    ovf_d       = (~s_q &  sa_q &  sb_q & ~sum_bit) |
                                  (~s_q & ~sa_q & ~sb_q &  sum_bit) |
                                  ( s_q &  sa_q & ~sb_q & ~sum_bit) |
                                  ( s_q & ~sa_q &  sb_q &  sum_bit);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: datapath registers are reset too, since result/flags must read 0 after reset.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            s_q         <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign carry_out = carry_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: directed operations push expected
// results; a monitor pops and checks on every done pulse.
module tb_serial_addsub_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    typedef struct {
        string      name;
        logic [N-1:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;
    logic         ovf;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sb_q[$];

    serial_addsub_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: counts busy cycles per operation and scores each done pulse.
    initial begin
        int   busy_cycles = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"},  32'(result),    32'(e.res));
                    check({e.name, "_cout"},    32'(carry_out), 32'(e.cout));
                    check({e.name, "_ovf"},     32'(ovf),       32'(e.ovf));
                    check({e.name, "_latency"}, 32'(busy_cycles), 32'(N));
                end
                busy_cycles = 0;
            end else if (busy) begin
                busy_cycles++;
            end else begin
                busy_cycles = 0;
            end
        end
    end

    task automatic issue(string name, logic s, logic [N-1:0] aa, logic [N-1:0] bb,
                         logic [N-1:0] r, logic c, logic v);
        exp_t e;
        e.name = name; e.res = r; e.cout = c; e.ovf = v;
        sub = s; a = aa; b = bb; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * N && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_result", 32'(result),    32'd0);
        check("rst_cout",   32'(carry_out), 32'd0);
        check("rst_ovf",    32'(ovf),       32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("add_100_27", 1'b0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0);
        wait_done("add_100_27");
        @(negedge clk);
        issue("add_ovf", 1'b0, 8'h64, 8'h1C, 8'h80, 1'b0, 1'b1);
        wait_done("add_ovf");
        @(negedge clk);
        issue("sub_ovf", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        wait_done("sub_ovf");
        @(negedge clk);
        issue("sub_zero", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
        wait_done("sub_zero");
        @(negedge clk);
        issue("sub_borrow", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
        wait_done("sub_borrow");
        @(negedge clk);

        // Start pulse mid-RUN must be ignored; start during DONE is accepted.
        issue("add_1_1", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        sub = 1'b0; a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("add_1_1");
        issue("b2b_sub", 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1);
        wait_done("b2b_sub");
        @(negedge clk);

        // Reset during RUN aborts without a done pulse.
        sub = 1'b0; a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   32'(busy),      32'd0);
        check("abort_done",   32'(done),      32'd0);
        check("abort_result", 32'(result),    32'd0);
        check("abort_cout",   32'(carry_out), 32'd0);
        check("abort_ovf",    32'(ovf),       32'd0);
        repeat (2 * N) @(negedge clk);

        issue("post_abort", 1'b0, 8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0);
        wait_done("post_abort");
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
